mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: an instruction-fetch port and a data port share one
// single-ported memory. One access every two cycles, round-robin on contention,
// with alignment/range fault detection and load extension on the data side.
//
// Handshake: a request is taken in the cycle where req and ready are both high
// (the accept cycle T). ready is combinational, only ever high in IDLE for the
// granted requester, and low while rst is high. The response is a one-cycle
// valid pulse at T+2; data/err hold their last values while valid is low.
module mem_arbiter #(
  parameter int unsigned MEM_WORDS = 'h2404
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic        if_valid,
  output logic [31:0] if_data,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic        d_unsigned,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_wstrb,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;

  state_t      state_q, state_d;
  logic        last_d_q, last_d_d;   // 1: data port was granted most recently
  logic        grant_if, grant_d;
  logic        if_fault, d_fault;

  // Transaction attributes captured in the accept cycle
  logic        flt_q, we_q, uns_q;
  logic [1:0]  size_q, off_q;

  logic        if_valid_q, if_err_q, d_valid_q, d_err_q;
  logic [31:0] if_data_q, d_rdata_q;

  logic [31:0] rd_shift, load_data;

  // Fault decode for both ports, evaluated on the live request inputs
  always_comb begin
    if_fault = (|if_addr[1:0]) || ({2'b00, if_addr[31:2]} >= MEM_WORDS);
    d_fault  = ({2'b00, d_addr[31:2]} >= MEM_WORDS);
    case (d_size)
      2'b00:   d_fault = d_fault;
      2'b01:   d_fault = d_fault || d_addr[0];
      2'b10:   d_fault = d_fault || (|d_addr[1:0]);
      default: d_fault = 1'b1;
    endcase
  end

  // Round-robin grant, only in IDLE and never during reset
  always_comb begin
    grant_if = !rst && (state_q == IDLE) && if_req && (!d_req || last_d_q);
    grant_d  = !rst && (state_q == IDLE) && d_req && (!if_req || !last_d_q);
    if_ready = grant_if;
    d_ready  = grant_d;
  end

  // Next state and accept-cycle memory command
  always_comb begin
    state_d   = IDLE;
    last_d_d  = last_d_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_wstrb = 4'b0000;
    mem_addr  = 30'd0;
    mem_wdata = 32'd0;
    case (state_q)
      IDLE: begin
        if (grant_if) begin
          state_d  = BUSY_IF;
          last_d_d = 1'b0;
          mem_addr = if_addr[31:2];
          mem_en   = !if_fault;
        end else if (grant_d) begin
          state_d  = BUSY_D;
          last_d_d = 1'b1;
          mem_addr = d_addr[31:2];
          mem_en   = !d_fault;
          mem_we   = !d_fault && d_we;
          if (!d_fault && d_we) begin
            case (d_size)
              2'b00: begin
                mem_wstrb = 4'b0001 << d_addr[1:0];
                mem_wdata = {4{d_wdata[7:0]}};
              end
              2'b01: begin
                mem_wstrb = d_addr[1] ? 4'b1100 : 4'b0011;
                mem_wdata = {2{d_wdata[15:0]}};
              end
              default: begin
                mem_wstrb = 4'b1111;
                mem_wdata = d_wdata;
              end
            endcase
          end
        end
      end
      default: state_d = IDLE;   // BUSY_IF / BUSY_D last exactly one cycle
    endcase
  end

  // State and arbitration history
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_d_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
    end
  end

  // Capture request attributes on accept so later input changes are ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      flt_q  <= 1'b0;
      we_q   <= 1'b0;
      uns_q  <= 1'b0;
      size_q <= 2'b00;
      off_q  <= 2'b00;
    end else if (grant_if) begin
      flt_q  <= if_fault;
      we_q   <= 1'b0;
      uns_q  <= 1'b0;
      size_q <= 2'b10;
      off_q  <= 2'b00;
    end else if (grant_d) begin
      flt_q  <= d_fault;
      we_q   <= d_we;
      uns_q  <= d_unsigned;
      size_q <= d_size;
      off_q  <= d_addr[1:0];
    end
  end

  // Load lane select and sign/zero extension from the returned word
  always_comb begin
    rd_shift = mem_rdata >> {off_q, 3'b000};
    case (size_q)
      2'b00:   load_data = {{24{!uns_q && rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   load_data = off_q[1] ? {{16{!uns_q && mem_rdata[31]}}, mem_rdata[31:16]}
                                    : {{16{!uns_q && mem_rdata[15]}}, mem_rdata[15:0]};
      default: load_data = mem_rdata;
    endcase
  end

  // Response registers: one-cycle valid pulse, data/err held between pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid_q <= 1'b0;
      if_err_q   <= 1'b0;
      if_data_q  <= 32'd0;
      d_valid_q  <= 1'b0;
      d_err_q    <= 1'b0;
      d_rdata_q  <= 32'd0;
    end else begin
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      if (state_q == BUSY_IF) begin
        if_valid_q <= 1'b1;
        if_err_q   <= flt_q;
        if_data_q  <= flt_q ? 32'd0 : mem_rdata;
      end
      if (state_q == BUSY_D) begin
        d_valid_q <= 1'b1;
        d_err_q   <= flt_q;
        d_rdata_q <= (flt_q || we_q) ? 32'd0 : load_data;
      end
    end
  end

  assign if_valid = if_valid_q;
  assign if_err   = if_err_q;
  assign if_data  = if_data_q;
  assign d_valid  = d_valid_q;
  assign d_err    = d_err_q;
  assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small behavioural memory.
module tb_mem_arbiter;

  localparam int unsigned MEM_WORDS = 'h2404;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready, if_valid, if_err;
  logic [31:0] if_data;
  logic        d_req, d_we, d_unsigned;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata;
  logic        d_ready, d_valid, d_err;
  logic [31:0] d_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_wstrb;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] prev_if_data, prev_d_rdata;

  mem_arbiter #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_valid(if_valid),
    .if_data(if_data), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(d_ready), .d_valid(d_valid),
    .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // behavioural memory: one-cycle read latency, byte-strobed writes
  logic [31:0] bmem [0:63];

  function automatic logic [31:0] init_word(input int i);
    case (i)
      0: return 32'h80FF7F01;
      1: return 32'h11112222;
      2: return 32'h33334444;
      3: return 32'h55556666;
      default: return 32'hA0000000 | 32'(i);
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) bmem[i] <= init_word(i);
      mem_rdata <= 32'd0;
    end else if (mem_en) begin
      mem_rdata <= bmem[mem_addr[5:0]];
      if (mem_we)
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) bmem[mem_addr[5:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
  end

  // scoreboard check
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver: one data transaction starting at a negedge, returns at T+2 negedge
  task automatic data_txn(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic exp_en, input logic [3:0] exp_strb,
                          input logic [31:0] exp_wdata, input logic exp_err,
                          input logic [31:0] exp_rdata);
    d_req = 1'b1; d_we = we; d_size = size; d_unsigned = uns;
    d_addr = addr; d_wdata = wdata;
    #1;
    chk("d_ready@T", {31'd0, d_ready}, 32'd1);
    chk("mem_en@T", {31'd0, mem_en}, {31'd0, exp_en});
    if (exp_en) begin
      chk("mem_addr@T", {2'b00, mem_addr}, {2'b00, addr[31:2]});
      chk("mem_we@T", {31'd0, mem_we}, {31'd0, we});
      if (we) begin
        chk("mem_wstrb@T", {28'd0, mem_wstrb}, {28'd0, exp_strb});
        chk("mem_wdata@T", mem_wdata, exp_wdata);
      end
    end
    @(negedge clk);
    d_req = 1'b0; d_we = 1'($urandom); d_size = 2'($urandom_range(0, 3));
    d_addr = $urandom; d_wdata = $urandom;
    chk("d_valid@T+1", {31'd0, d_valid}, 32'd0);
    chk("d_rdata_hold", d_rdata, prev_d_rdata);
    chk("mem_en@T+1", {31'd0, mem_en}, 32'd0);
    @(negedge clk);
    chk("d_valid@T+2", {31'd0, d_valid}, 32'd1);
    chk("d_err@T+2", {31'd0, d_err}, {31'd0, exp_err});
    chk("d_rdata@T+2", d_rdata, exp_rdata);
    prev_d_rdata = exp_rdata;
  endtask

  // driver: one fetch transaction starting at a negedge, returns at T+2 negedge
  task automatic fetch_txn(input logic [31:0] addr, input logic exp_err,
                           input logic [31:0] exp_data);
    if_req = 1'b1; if_addr = addr;
    #1;
    chk("if_ready@T", {31'd0, if_ready}, 32'd1);
    chk("if_mem_en@T", {31'd0, mem_en}, {31'd0, !exp_err});
    if (!exp_err) chk("if_mem_addr@T", {2'b00, mem_addr}, {2'b00, addr[31:2]});
    @(negedge clk);
    if_req = 1'b0; if_addr = $urandom;
    chk("if_valid@T+1", {31'd0, if_valid}, 32'd0);
    chk("if_data_hold", if_data, prev_if_data);
    @(negedge clk);
    chk("if_valid@T+2", {31'd0, if_valid}, 32'd1);
    chk("if_err@T+2", {31'd0, if_err}, {31'd0, exp_err});
    chk("if_data@T+2", if_data, exp_data);
    prev_if_data = exp_data;
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b1; if_addr = 32'h4; d_req = 1'b1; d_we = 1'b0;
    d_size = 2'b10; d_unsigned = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    prev_if_data = 32'd0; prev_d_rdata = 32'd0;
    repeat (3) @(negedge clk);

    // reset state: readies forced low, responses cleared
    chk("rst_if_ready", {31'd0, if_ready}, 32'd0);
    chk("rst_d_ready", {31'd0, d_ready}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_valids", {30'd0, if_valid, d_valid}, 32'd0);
    chk("rst_errs", {30'd0, if_err, d_err}, 32'd0);
    chk("rst_if_data", if_data, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);

    // contention from reset: fetch first, data two cycles later
    rst = 1'b0;
    #1;
    chk("cont_if_ready@T", {31'd0, if_ready}, 32'd1);
    chk("cont_d_ready@T", {31'd0, d_ready}, 32'd0);
    chk("cont_mem_addr@T", {2'b00, mem_addr}, 32'd1);
    @(negedge clk);
    chk("cont_readies@T+1", {30'd0, if_ready, d_ready}, 32'd0);
    @(negedge clk);
    chk("cont_if_valid@T+2", {31'd0, if_valid}, 32'd1);
    chk("cont_if_data@T+2", if_data, 32'h11112222);
    chk("cont_d_ready@T+2", {31'd0, d_ready}, 32'd1);
    chk("cont_if_ready@T+2", {31'd0, if_ready}, 32'd0);
    chk("cont_mem_addr@T+2", {2'b00, mem_addr}, 32'd0);
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0;
    chk("cont_if_valid@T+3", {31'd0, if_valid}, 32'd0);
    @(negedge clk);
    chk("cont_d_valid@T+4", {31'd0, d_valid}, 32'd1);
    chk("cont_d_rdata@T+4", d_rdata, 32'h80FF7F01);
    prev_if_data = 32'h11112222; prev_d_rdata = 32'h80FF7F01;

    // loads with extension from word 0 = 80FF7F01
    data_txn(0, 2'b00, 0, 32'h2, 0, 1, 4'h0, 0, 0, 32'hFFFFFFFF);
    data_txn(0, 2'b00, 1, 32'h2, 0, 1, 4'h0, 0, 0, 32'h000000FF);
    data_txn(0, 2'b00, 0, 32'h1, 0, 1, 4'h0, 0, 0, 32'h0000007F);
    data_txn(0, 2'b00, 0, 32'h3, 0, 1, 4'h0, 0, 0, 32'hFFFFFF80);
    data_txn(0, 2'b01, 0, 32'h2, 0, 1, 4'h0, 0, 0, 32'hFFFF80FF);
    data_txn(0, 2'b01, 1, 32'h2, 0, 1, 4'h0, 0, 0, 32'h000080FF);
    data_txn(0, 2'b01, 0, 32'h0, 0, 1, 4'h0, 0, 0, 32'h00007F01);

    // stores, then read back
    data_txn(1, 2'b01, 0, 32'h6, 32'h1234ABCD, 1, 4'b1100, 32'hABCDABCD, 0, 32'h0);
    data_txn(0, 2'b10, 0, 32'h4, 0, 1, 4'h0, 0, 0, 32'hABCD2222);
    data_txn(1, 2'b00, 0, 32'h9, 32'h12345655, 1, 4'b0010, 32'h55555555, 0, 32'h0);
    data_txn(0, 2'b10, 0, 32'h8, 0, 1, 4'h0, 0, 0, 32'h33335544);
    data_txn(1, 2'b10, 0, 32'hC, 32'hDEADBEEF, 1, 4'b1111, 32'hDEADBEEF, 0, 32'h0);

    // faults: misaligned word/half, reserved size, out of range; then a clean load
    data_txn(0, 2'b10, 0, 32'h2, 0, 0, 4'h0, 0, 1, 32'h0);
    data_txn(0, 2'b01, 0, 32'h1, 0, 0, 4'h0, 0, 1, 32'h0);
    data_txn(1, 2'b11, 0, 32'h0, 32'hFFFFFFFF, 0, 4'h0, 0, 1, 32'h0);
    data_txn(0, 2'b10, 0, MEM_WORDS << 2, 0, 0, 4'h0, 0, 1, 32'h0);
    data_txn(0, 2'b10, 0, 32'hC, 0, 1, 4'h0, 0, 0, 32'hDEADBEEF);

    // back-to-back fetches, including the word just stored
    fetch_txn(32'h10, 0, 32'hA0000004);
    fetch_txn(32'h14, 0, 32'hA0000005);
    fetch_txn(32'hC, 0, 32'hDEADBEEF);
    fetch_txn(MEM_WORDS << 2, 1, 32'h0);
    fetch_txn(32'h2, 1, 32'h0);
    fetch_txn(32'h18, 0, 32'hA0000006);

    // reset asserted at T+1 of an accepted load
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h4;
    #1;
    chk("mid_d_ready@T", {31'd0, d_ready}, 32'd1);
    @(negedge clk);
    d_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("mid_d_valid@T+2", {31'd0, d_valid}, 32'd0);
    chk("mid_if_valid", {31'd0, if_valid}, 32'd0);
    chk("mid_d_rdata", d_rdata, 32'd0);
    chk("mid_if_data", if_data, 32'd0);
    chk("mid_errs", {30'd0, if_err, d_err}, 32'd0);
    chk("mid_mem_cmd", {30'd0, mem_en, mem_we}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_d_valid@T+3", {31'd0, d_valid}, 32'd0);
    chk("mid_mem_en@T+3", {31'd0, mem_en}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
